// File: rtl/md_pkg.sv
// Shared encodings and latencies for the multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } mdOp_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_e;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath producing HI/LO candidates.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic        isSgn;
  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] den;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        negQ;
  logic        negR;

  assign isSgn = (op == MD_MULT) || (op == MD_DIV);

  assign prodS = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prodU = {32'd0, A} * {32'd0, B};

  // Divide on magnitudes so the most-negative dividend needs no special case
  assign magA = (isSgn && A[31]) ? (32'd0 - A) : A;
  assign magB = (isSgn && B[31]) ? (32'd0 - B) : B;
  assign den  = (magB == 32'd0) ? 32'd1 : magB;
  assign quo  = magA / den;
  assign rem  = magA % den;
  assign negQ = isSgn && (A[31] ^ B[31]);
  assign negR = isSgn && A[31];

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    unique case (1'b1)
      op == MD_MULT: begin
        hi = prodS[63:32];
        lo = prodS[31:0];
      end
      op == MD_MULTU: begin
        hi = prodU[63:32];
        lo = prodU[31:0];
      end
      (op == MD_DIV) || (op == MD_DIVU): begin
        hi = negR ? (32'd0 - rem) : rem;
        lo = negQ ? (32'd0 - quo) : quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle HI/LO controller: issue, busy countdown, writeback.
module md_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  mdState_e    state;
  logic [3:0]  cnt;
  logic [31:0] pendHi;
  logic [31:0] pendLo;
  logic        pendWr;
  logic [31:0] arHi;
  logic [31:0] arLo;
  logic        isMul;
  logic        isDiv;

  md_arith uArith (
    .op (md_op),
    .A  (A),
    .B  (B),
    .hi (arHi),
    .lo (arLo)
  );

  assign isMul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign isDiv    = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign stall_md = md_use_D & (busy | isMul | isDiv);
  assign md_out   = hilo_sel ? HI : LO;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      busy   <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      pendHi <= 32'd0;
      pendLo <= 32'd0;
      pendWr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            isMul: begin
              pendHi <= arHi;
              pendLo <= arLo;
              pendWr <= 1'b1;
              cnt    <= MUL_LAT;
              busy   <= 1'b1;
              state  <= BUSY;
            end
            isDiv: begin
              pendHi <= arHi;
              pendLo <= arLo;
              // Divide by zero still burns the full latency
              pendWr <= (B != 32'd0);
              cnt    <= DIV_LAT;
              busy   <= 1'b1;
              state  <= BUSY;
            end
            md_op == MD_MTHI: HI <= A;
            md_op == MD_MTLO: LO <= A;
            default: ;
          endcase
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (pendWr) begin
              HI <= pendHi;
              LO <= pendLo;
            end
            pendWr <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL provide clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide md_op  input  3  E-stage MD command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-004 SHALL provide A  input  32  E-stage forwarded rs value.
REQ-005 SHALL provide B  input  32  E-stage forwarded rt value.
REQ-006 SHALL provide md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-007 SHALL provide hilo_sel  input  1  read select for mfhi/mflo: 1 HI, 0 LO.
REQ-008 SHALL provide busy  output  1  operation in progress.
REQ-009 SHALL provide stall_md  output  1  stall request to the D/E hazard logic.
REQ-010 SHALL provide HI  output  32  architectural HI register.
REQ-011 SHALL provide LO  output  32  architectural LO register.
REQ-012 SHALL provide md_out  output  32  hilo_sel ? HI : LO, combinational.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY plus a 4-bit down-counter cnt.
REQ-014 In IDLE, md_op in {1,2} at edge T SHALL latch the 64-bit product into pending regs, load cnt=5, enter BUSY.
REQ-015 In IDLE, md_op in {3,4} at edge T SHALL latch quotient/remainder into pending regs, load cnt=10, enter BUSY.
REQ-016 busy SHALL be 1 for exactly 5 (mult) / 10 (div) cycles after edge T; at the edge where cnt goes 1->0, HI/LO SHALL take the pending values and FSM SHALL return to IDLE.
REQ-017 Net latency: HI/LO new values visible and busy=0 in cycle T+6 (mult) / T+11 (div).
REQ-018 mult/div: HI=upper 32 bits, LO=lower 32 bits; signed vs unsigned per op.
REQ-019 Signed div: LO=quotient truncated toward zero; HI=remainder with sign of dividend.
REQ-020 Divide by zero (B=0) SHALL still occupy BUSY 10 cycles and SHALL leave HI/LO unchanged.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 mthi/mtlo in IDLE SHALL write A to HI/LO at that edge, no BUSY entry.
REQ-023 stall_md SHALL equal md_use_D & (busy | (md_op in {1..4})), combinational.
REQ-024 Nonzero md_op while BUSY SHALL be ignored (protocol violation; stall_md prevents it) and flagged by bench assertion.
REQ-025 md_out SHALL return the current architectural HI/LO, never pending values.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, cnt=0, HI=0, LO=0, busy=0, and discard pending results, including mid-operation.
REQ-027 md_op asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-028 Op encodings (MD_NONE..MD_MTLO) and latencies (MUL_LAT=5, DIV_LAT=10) SHALL live in shared package md_pkg.
REQ-029 Arithmetic SHALL be one combinational sub-module md_arith (op, A, B -> hi, lo); md_ctrl holds FSM, counter, and registers.

Verification
REQ-030 mult A=0xFFFFFFFF, B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=1, LO=0xFFFFFFFE.
REQ-031 div A=-7, B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-032 With HI=0x11, LO=0x22, div B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-033 mult issued, md_use_D=1 held -> stall_md=1 in issue cycle and all busy cycles, 0 in T+6.
REQ-034 mthi A=0x1234 then mflo/mfhi reads -> HI=0x1234 next cycle, busy never asserted, md_out tracks hilo_sel.
REQ-035 reset at cycle 3 of div -> next cycle busy=0, HI=LO=0, no later writeback.
